// File: rtl/test_harness_pkg.sv
// Shared definitions for the ADC loopback self-test harness.
//   state_e       : sequencer states
//   *_DEF         : default parameter values for the top level
//   BIAS_CODE     : mid-scale bias code driven back to the ADC
//   adc_diff()    : 9-bit signed differential of two unsigned 8-bit legs
package test_harness_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_CHECK   = 3'd3,
    ST_PASS    = 3'd4,
    ST_FAIL    = 3'd5
  } state_e;

  localparam int SETTLE_CYCLES_DEF = 16;
  localparam int WINDOW_DEF        = 1024;
  localparam int MIN_SWING_DEF     = 64;
  localparam int MIN_XING_DEF      = 2;
  localparam int MAX_XING_DEF      = 64;

  localparam logic [7:0] BIAS_CODE = 8'd128;

  // 255 - 0 and 0 - 255 both fit in 9 signed bits, so no saturation.
  function automatic logic signed [8:0] adc_diff(input logic [7:0] p, input logic [7:0] m);
    return $signed({1'b0, p}) - $signed({1'b0, m});
  endfunction

endpackage

// File: rtl/test_harness_if.sv
// Control and ADC signals of the self-test harness.
//   master : environment side (drives resets and ADC codes, sees flags/bias)
//   slave  : harness side
// There is no valid/ready handshake here: an ADC code is offered every
// cycle and is taken whenever the harness is measuring and
// io_adcclkreset is low.
interface test_harness_if;
  logic       io_core_reset;
  logic       io_dsp_reset;
  logic       io_adcclkreset;
  logic [7:0] io_ADCINP;
  logic [7:0] io_ADCINM;
  logic [7:0] io_ADCBIAS;
  logic       io_success;
  logic       io_failure;

  modport master (
    output io_core_reset, io_dsp_reset, io_adcclkreset, io_ADCINP, io_ADCINM,
    input  io_ADCBIAS, io_success, io_failure
  );

  modport slave (
    input  io_core_reset, io_dsp_reset, io_adcclkreset, io_ADCINP, io_ADCINM,
    output io_ADCBIAS, io_success, io_failure
  );
endinterface

// File: rtl/test_harness_adc_stats.sv
// adc_stats: measurement datapath of the harness.
//   clock, reset : clock / async active-low reset
//   clear        : synchronous clear of all statistics (core or dsp reset)
//   accept       : take the ADC codes presented this cycle as a sample
//   adc_p, adc_m : ADC leg codes
//   max_diff, min_diff, xing_cnt : statistics of the current window
//   window_done  : WINDOW samples have been accumulated
// Stage 1 registers the raw codes; stage 2 updates the statistics, giving
// a two-cycle sample latency.
module adc_stats
  import test_harness_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        adc_p,
  input  logic [7:0]        adc_m,
  output logic signed [8:0] max_diff,
  output logic signed [8:0] min_diff,
  output logic [6:0]        xing_cnt,
  output logic              window_done
);

  localparam logic [10:0]       WIN      = 11'(WINDOW);
  localparam logic signed [8:0] DIFF_LOW = 9'h100;  // -256
  localparam logic signed [8:0] DIFF_TOP = 9'h0FF;  // +255
  localparam logic [6:0]        XING_SAT = 7'd127;

  logic [7:0]        p_q, m_q;
  logic              acc_q;
  logic signed [8:0] diff;
  logic signed [8:0] prev_diff;
  logic              have_prev;
  logic [10:0]       sample_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_q   <= '0;
      m_q   <= '0;
      acc_q <= 1'b0;
    end else begin
      p_q   <= adc_p;
      m_q   <= adc_m;
      // A sample in flight when statistics clear belongs to the old window.
      acc_q <= accept && !clear;
    end
  end

  assign diff = adc_diff(p_q, m_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      max_diff   <= DIFF_LOW;
      min_diff   <= DIFF_TOP;
      xing_cnt   <= '0;
      sample_cnt <= '0;
      prev_diff  <= '0;
      have_prev  <= 1'b0;
    end else if (clear) begin
      max_diff   <= DIFF_LOW;
      min_diff   <= DIFF_TOP;
      xing_cnt   <= '0;
      sample_cnt <= '0;
      prev_diff  <= '0;
      have_prev  <= 1'b0;
    end else if (acc_q && (sample_cnt < WIN)) begin
      // Samples still in the pipe after the window filled are dropped.
      if (diff > max_diff) max_diff <= diff;
      if (diff < min_diff) min_diff <= diff;
      if (have_prev && prev_diff[8] && !diff[8] && (xing_cnt != XING_SAT))
        xing_cnt <= xing_cnt + 7'd1;
      prev_diff  <= diff;
      have_prev  <= 1'b1;
      sample_cnt <= sample_cnt + 11'd1;
    end
  end

  assign window_done = (sample_cnt == WIN);

endmodule

// File: rtl/test_harness.sv
// test_harness: ADC loopback self-test sequencer.
//   clock : sole clock (rising edge)
//   reset : asynchronous active-low global reset
//   bus   : test_harness_if.slave -- sequencer/dsp/sampler resets, ADC
//           legs in, bias code and sticky success/failure flags out
// Sequence: IDLE -> SETTLE (SETTLE_CYCLES) -> MEASURE (WINDOW samples)
// -> CHECK (one cycle) -> PASS or FAIL, both terminal until a reset.
// The current state is held in 'state' for observation.
module test_harness
  import test_harness_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int WINDOW        = WINDOW_DEF,
  parameter int MIN_SWING     = MIN_SWING_DEF,
  parameter int MIN_XING      = MIN_XING_DEF,
  parameter int MAX_XING      = MAX_XING_DEF
) (
  input logic            clock,
  input logic            reset,
  test_harness_if.slave  bus
);

  localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic signed [9:0] SWING_MIN   = 10'(MIN_SWING);
  localparam logic [6:0]        XING_LO     = 7'(MIN_XING);
  localparam logic [6:0]        XING_HI     = 7'(MAX_XING);

  state_e            state;
  logic [7:0]        settle_cnt;
  logic              success_q, failure_q;

  logic signed [8:0] max_diff, min_diff;
  logic [6:0]        xing_cnt;
  logic              window_done;
  logic              stats_clear;
  logic              accept;
  logic signed [9:0] swing;
  logic              pass_ok;

  assign stats_clear = bus.io_core_reset || bus.io_dsp_reset;
  assign accept      = (state == ST_MEASURE) && !bus.io_adcclkreset;

  adc_stats #(.WINDOW(WINDOW)) u_stats (
    .clock       (clock),
    .reset       (reset),
    .clear       (stats_clear),
    .accept      (accept),
    .adc_p       (bus.io_ADCINP),
    .adc_m       (bus.io_ADCINM),
    .max_diff    (max_diff),
    .min_diff    (min_diff),
    .xing_cnt    (xing_cnt),
    .window_done (window_done)
  );

  // One extra bit so max - min cannot wrap (range -511..+511).
  assign swing   = {max_diff[8], max_diff} - {min_diff[8], min_diff};
  assign pass_ok = (swing >= SWING_MIN) && (xing_cnt >= XING_LO) && (xing_cnt <= XING_HI);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      success_q  <= 1'b0;
      failure_q  <= 1'b0;
    end else if (bus.io_core_reset) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      success_q  <= 1'b0;
      failure_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= ST_MEASURE;
          else                           settle_cnt <= settle_cnt + 8'd1;
        end
        ST_MEASURE: begin
          // A coinciding dsp reset restarts the window instead.
          if (window_done && !bus.io_dsp_reset) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (pass_ok) begin
            state     <= ST_PASS;
            success_q <= 1'b1;
          end else begin
            state     <= ST_FAIL;
            failure_q <= 1'b1;
          end
        end
        ST_PASS, ST_FAIL: state <= state;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.io_success = success_q;
  assign bus.io_failure = failure_q;
  assign bus.io_ADCBIAS = BIAS_CODE;

endmodule

// File: tb/tb_test_harness.sv
// Bench for test_harness: stimulus arrays are filled per run, a reference
// model derives the expected verdict and flag cycle from them and pushes it
// into exp_q; a monitor pops an entry whenever a flag rises.
module tb_test_harness;
  import test_harness_pkg::*;

  localparam int MAXN   = 3000;
  localparam int NOMINAL = 16 + 1024 + 2 + 1;

  logic clock = 1'b0;
  logic reset;
  test_harness_if th_if ();

  test_harness dut (
    .clock (clock),
    .reset (reset),
    .bus   (th_if)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- stimulus storage ----------------
  logic [7:0] p_arr [MAXN];
  logic [7:0] m_arr [MAXN];
  logic       hold_arr [MAXN];
  logic       dsp_arr [MAXN];

  logic [31:0] exp_q[$];   // {expect_pass, flag cycle offset from sequence start}
  int total = 0;
  int bad   = 0;
  int seq_start = 0;
  int last_rel  = -1;
  int base_rel  = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic prev_s = 1'b0, prev_f = 1'b0;
  always @(negedge clock) begin
    logic [31:0] e;
    int rel;
    total++;
    if (th_if.io_success === 1'b1 && th_if.io_failure === 1'b1) begin
      bad++;
      $display("FAIL flags_exclusive: success=%0b failure=%0b, expected not both 1",
               th_if.io_success, th_if.io_failure);
    end
    if ((th_if.io_success && !prev_s) || (th_if.io_failure && !prev_f)) begin
      rel = cyc - seq_start;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_flag: success=%0b failure=%0b at offset %0d, expected none",
                 th_if.io_success, th_if.io_failure, rel);
      end else begin
        e = exp_q.pop_front();
        if (th_if.io_success !== e[31] || th_if.io_failure !== !e[31] || rel != int'(e[30:0])) begin
          bad++;
          $display("FAIL verdict: success=%0b failure=%0b offset=%0d, expected success=%0b offset=%0d",
                   th_if.io_success, th_if.io_failure, rel, e[31], e[30:0]);
        end
      end
      last_rel = rel;
    end
    prev_s = th_if.io_success;
    prev_f = th_if.io_failure;
  end

  // ---------------- reference model ----------------
  // Sequence start S is the first edge out of IDLE; SETTLE occupies 16
  // cycles, so codes offered for edges S+17 onward are candidate samples.
  // A dsp reset discards everything taken up to and including its edge.
  // Verdict appears 2 (latency) + 1 (check) edges after the last sample.
  function automatic logic [31:0] predict();
    int win[$];
    int last = -1;
    int mx = -256, mn = 255, x = 0;
    logic pass;
    for (int k = 17; k < MAXN; k++) begin
      if (dsp_arr[k]) begin
        win.delete();
        continue;
      end
      if (!hold_arr[k]) begin
        win.push_back(int'(p_arr[k]) - int'(m_arr[k]));
        if (win.size() == 1024) begin
          last = k;
          break;
        end
      end
    end
    if (last < 0) return {1'b0, 31'(MAXN)};
    foreach (win[i]) begin
      if (win[i] > mx) mx = win[i];
      if (win[i] < mn) mn = win[i];
      if (i > 0 && win[i-1] < 0 && win[i] >= 0) x++;
    end
    pass = ((mx - mn) >= 64) && (x >= 2) && (x <= 64);
    return {pass, 31'(last + 3)};
  endfunction

  // ---------------- stimulus builders ----------------
  task automatic clear_ctl();
    for (int i = 0; i < MAXN; i++) begin
      hold_arr[i] = 1'b0;
      dsp_arr[i]  = 1'b0;
    end
  endtask

  task automatic fill_sine(input int amp, input int per);
    real s;
    int d;
    clear_ctl();
    for (int i = 0; i < MAXN; i++) begin
      s = $sin(2.0 * 3.14159265358979 * real'(i) / real'(per));
      d = int'(real'(amp) * s);
      p_arr[i] = 8'(128 + d);
      m_arr[i] = 8'(128 - d);
    end
  endtask

  task automatic fill_const();
    clear_ctl();
    for (int i = 0; i < MAXN; i++) begin
      p_arr[i] = 8'd128;
      m_arr[i] = 8'd128;
    end
  endtask

  task automatic fill_square();
    clear_ctl();
    for (int i = 0; i < MAXN; i++) begin
      p_arr[i] = ((i / 4) % 2 == 0) ? 8'd178 : 8'd78;
      m_arr[i] = ((i / 4) % 2 == 0) ? 8'd78  : 8'd178;
    end
  endtask

  task automatic fill_noise();
    clear_ctl();
    for (int i = 0; i < MAXN; i++) begin
      p_arr[i] = 8'($urandom_range(0, 255));
      m_arr[i] = 8'($urandom_range(0, 255));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int n);
    for (int i = 0; i < n; i++) begin
      th_if.io_ADCINP      = p_arr[i];
      th_if.io_ADCINM      = m_arr[i];
      th_if.io_adcclkreset = hold_arr[i];
      th_if.io_dsp_reset   = dsp_arr[i];
      @(negedge clock);
    end
    th_if.io_ADCINP      = 8'd128;
    th_if.io_ADCINM      = 8'd128;
    th_if.io_adcclkreset = 1'b0;
    th_if.io_dsp_reset   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  // Called at a negedge with reset low (or core reset high); releases it.
  task automatic run_seq(input bit via_core);
    logic [31:0] e;
    e = predict();
    exp_q.push_back(e);
    if (via_core) th_if.io_core_reset = 1'b0;
    else          reset = 1'b1;
    seq_start = cyc + 1;
    drive(int'(e[30:0]) + 4);
    repeat (2) @(negedge clock);
    check("flag_timeout_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- main ----------------
  initial begin
    reset                = 1'b1;
    th_if.io_core_reset  = 1'b0;
    th_if.io_dsp_reset   = 1'b0;
    th_if.io_adcclkreset = 1'b0;
    th_if.io_ADCINP      = 8'd128;
    th_if.io_ADCINM      = 8'd128;
    #1 reset = 1'b0;
    #1;
    check("reset_success", int'(th_if.io_success), 0);
    check("reset_failure", int'(th_if.io_failure), 0);
    check("reset_bias", int'(th_if.io_ADCBIAS), int'(BIAS_CODE));
    repeat (3) @(negedge clock);

    // Sine -> PASS at the nominal cycle
    fill_sine(38, 64);
    run_seq(1'b0);
    base_rel = last_rel;
    check("sine_pass_cycle", base_rel, NOMINAL);

    // Asynchronous reset clears the flag before any clock edge
    #2 reset = 1'b0;
    #1;
    check("async_reset_success", int'(th_if.io_success), 0);
    check("async_reset_bias", int'(th_if.io_ADCBIAS), 128);
    repeat (3) @(negedge clock);

    // Constant mid-scale -> FAIL
    fill_const();
    run_seq(1'b0);

    // Square wave with too many crossings -> FAIL
    fill_square();
    do_reset();
    run_seq(1'b0);

    // Sampler hold for 500 mid-window cycles -> PASS 500 cycles later
    fill_sine(38, 64);
    for (int i = 17 + 300; i < 17 + 800; i++) hold_arr[i] = 1'b1;
    do_reset();
    run_seq(1'b0);
    check("hold_delay", last_rel - base_rel, 500);

    // core reset in PASS: flag drops next cycle, full sequence recurs
    th_if.io_core_reset = 1'b1;
    @(negedge clock);
    check("core_reset_drop", int'(th_if.io_success), 0);
    fill_sine(38, 64);
    run_seq(1'b1);
    check("core_reset_rerun", last_rel, NOMINAL);

    // Reset mid-MEASURE: flags 0, then a fresh full sequence
    do_reset();
    reset = 1'b1;
    drive(600);
    #2 reset = 1'b0;
    #1;
    check("mid_measure_success", int'(th_if.io_success), 0);
    check("mid_measure_failure", int'(th_if.io_failure), 0);
    repeat (3) @(negedge clock);
    run_seq(1'b0);
    check("mid_measure_rerun", last_rel, NOMINAL);

    // dsp reset at accepted sample 1000 restarts the window
    fill_sine(38, 64);
    dsp_arr[17 + 1000] = 1'b1;
    do_reset();
    run_seq(1'b0);
    check("dsp_restart_cycle", last_rel, 17 + 1000 + 1024 + 3);

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      case ($urandom_range(0, 2))
        0: fill_sine($urandom_range(0, 60), $urandom_range(6, 120));
        1: fill_noise();
        default: begin
          fill_sine($urandom_range(10, 60), $urandom_range(20, 100));
          for (int i = 0; i < MAXN; i++) hold_arr[i] = ($urandom_range(0, 7) == 0);
        end
      endcase
      do_reset();
      run_seq(1'b0);
    end

    check("bias_final", int'(th_if.io_ADCBIAS), 128);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/test_harness.md
TEST_HARNESS -- requirements
Module: test_harness

Interface
REQ-001 Parameters SHALL be: SETTLE_CYCLES 16 (post-reset wait before measuring); WINDOW 1024 (samples per measurement window); MIN_SWING 64 (minimum peak-to-peak differential code); MIN_XING 2 and MAX_XING 64 (allowed rising zero-crossing count per window); BIAS_CODE 8'd128 (mid-scale ADC bias).
REQ-002 Ports SHALL be:
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low global reset.
- io_core_reset  in  1  synchronous active-high sequencer restart.
- io_dsp_reset  in  1  synchronous active-high clear of measurement statistics.
- io_adcclkreset  in  1  synchronous active-high sampler hold; no samples taken while high.
- io_ADCINP  in  8  unsigned positive-leg ADC code.
- io_ADCINM  in  8  unsigned negative-leg ADC code.
- io_ADCBIAS  out  8  constant BIAS_CODE.
- io_success  out  1  sticky self-test pass flag.
- io_failure  out  1  sticky self-test fail flag.

Function
REQ-003 Differential sample SHALL be diff = io_ADCINP - io_ADCINM as 9-bit signed; no saturation is needed.
REQ-004 Inputs SHALL be registered once; sample latency to the statistics registers SHALL be 2 cycles.
REQ-005 The sequencer SHALL have states IDLE, SETTLE, MEASURE, CHECK, PASS and FAIL.
REQ-006 IDLE SHALL go to SETTLE on the first cycle after reset deassertion.
REQ-007 SETTLE SHALL last exactly SETTLE_CYCLES cycles and then go to MEASURE.
REQ-008 MEASURE SHALL accept one sample per cycle while io_adcclkreset is low; cycles with io_adcclkreset high SHALL neither count nor update statistics.
REQ-009 MEASURE SHALL go to CHECK after WINDOW accepted samples.
REQ-010 In MEASURE the block SHALL track: max diff and min diff (initialised to -256 and +255); rising crossings, i.e. previous diff < 0 and current diff >= 0 (the first sample of a window is never a crossing); and the accepted-sample count (11 bits).
REQ-011 CHECK SHALL take one cycle and go to PASS iff (max - min) >= MIN_SWING, computed in 10-bit signed arithmetic, and MIN_XING <= crossings <= MAX_XING; otherwise it SHALL go to FAIL.
REQ-012 The crossing counter SHALL saturate at 127.
REQ-013 PASS and FAIL SHALL be terminal; they are left only by reset or io_core_reset.
REQ-014 io_success SHALL be 1 exactly in PASS and io_failure exactly in FAIL; both SHALL be registered outputs and never high together.
REQ-015 io_core_reset high SHALL, on the next edge, clear all statistics and return the sequencer to IDLE, with priority over every other event; the sequencer SHALL resume at IDLE when it drops.
REQ-016 io_dsp_reset high SHALL clear the statistics and sample count without changing state; if asserted during MEASURE, the window restarts.
REQ-017 If io_dsp_reset and a window-complete event coincide, io_dsp_reset SHALL win and MEASURE continues.

Reset
REQ-018 Asserting reset (low) SHALL asynchronously force state IDLE, statistics to their initial values, crossings and count to 0, and io_success and io_failure to 0.
REQ-019 io_ADCBIAS SHALL equal BIAS_CODE at all times, including during reset.
REQ-020 Reset release SHALL take effect on the first clock edge after deassertion.

Structure
REQ-021 The state enum, BIAS_CODE and default parameter values SHALL live in the shared package test_harness_pkg.
REQ-022 The statistics datapath (diff, min/max, crossing detect, counters) SHALL be the sub-module adc_stats, controlled by the top-level sequencer.

Verification
REQ-023 Sine stimulus: P = 128+38*sin, M = 128-38*sin, period 64 cycles, reset released -> io_success = 1 at cycle 16+1024+2+1 (within ±2), io_failure stays 0.
REQ-024 Constant P = M = 128 -> io_failure = 1 after the window, with swing 0 and crossings 0.
REQ-025 Square wave of ±100 differential with period 8 -> crossings 128 saturate to 127 (> MAX_XING) -> io_failure = 1.
REQ-026 Sine stimulus with io_adcclkreset high for 500 mid-window cycles -> PASS delayed by exactly 500 cycles.
REQ-027 io_core_reset pulsed in PASS -> io_success drops next cycle and PASS recurs after a full sequence; reset asserted mid-MEASURE -> immediate IDLE with both flags 0.
REQ-028 io_dsp_reset pulsed at accepted sample 1000 -> window restarts and completes 1024 samples later.
